// File: rtl/muldiv_seq_if.sv
// Request/response and multiplier-side signals of the M-extension sequencer.
// The sequencer itself uses the slave view; the execute stage and multiplier use the master view.
interface muldiv_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_ctrl;
  logic [31:0] i_dataa;
  logic [31:0] i_datab;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [1:0]  o_mul_s;
  logic [31:0] o_mul_a;
  logic [31:0] o_mul_b;
  logic [63:0] i_mul_out;

  modport slave (
    input  i_valid, i_ctrl, i_dataa, i_datab, i_flush, i_ready, i_mul_out,
    output o_ready, o_valid, o_result, o_mul_s, o_mul_a, o_mul_b
  );

  modport master (
    output i_valid, i_ctrl, i_dataa, i_datab, i_flush, i_ready, i_mul_out,
    input  o_ready, o_valid, o_result, o_mul_s, o_mul_a, o_mul_b
  );
endinterface

// File: rtl/muldiv_seq.sv
// M-extension sequencer: drives an external multiplier and runs a 1-bit-per-cycle
// restoring divider, holding one 32-bit result until the consumer takes it.
module muldiv_seq #(
  parameter int MUL_CYCLE = 1
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  if (MUL_CYCLE != 1 && MUL_CYCLE != 2) begin : g_bad_mul_cycle
    $error("muldiv_seq: MUL_CYCLE must be 1 or 2");
  end

  localparam logic [5:0] MUL_LAST = 6'(2 * MUL_CYCLE - 2);
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_MUL  = 4'b0000, OP_MULH = 4'b0001, OP_MULHSU = 4'b0010, OP_MULHU = 4'b0011,
    OP_DIV  = 4'b0100, OP_DIVU = 4'b0101, OP_REM    = 4'b0110, OP_REMU  = 4'b1011
  } op_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dvsr;
  logic        neg_q, neg_r;

  // Request decode, evaluated on the incoming operands during the accept cycle
  logic        accept, req_mul, req_div, req_signed, req_rem, req_slow_div;
  logic [31:0] fast_result;

  always_comb begin
    accept       = (state == S_IDLE) && bus.i_valid && !bus.i_flush;
    req_mul      = (bus.i_ctrl[3:2] == 2'b00);
    req_div      = bus.i_ctrl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    req_signed   = (bus.i_ctrl == OP_DIV) || (bus.i_ctrl == OP_REM);
    req_rem      = (bus.i_ctrl == OP_REM) || (bus.i_ctrl == OP_REMU);
    fast_result  = '0;
    req_slow_div = 1'b0;
    if (req_div && bus.i_datab == '0)
      fast_result = req_rem ? bus.i_dataa : 32'hFFFF_FFFF;
    else if (req_signed && bus.i_dataa == 32'h8000_0000 && bus.i_datab == 32'hFFFF_FFFF)
      fast_result = req_rem ? 32'h0 : 32'h8000_0000;
    else
      req_slow_div = req_div;
  end

  // One restoring step: shift the next dividend bit into the 33-bit partial remainder
  logic [32:0] rem_shift, rem_diff;
  assign rem_shift = {rem, quo[31]};
  assign rem_diff  = rem_shift - {1'b0, dvsr};

  logic        ctrl_rem;
  logic [31:0] q_fix, r_fix;
  assign ctrl_rem = (ctrl == OP_REM) || (ctrl == OP_REMU);
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -rem : rem;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (bus.i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.i_valid) state_nxt = req_mul ? S_MUL : (req_slow_div ? S_DIV : S_DONE);
        S_MUL:  if (cnt == MUL_LAST) state_nxt = S_DONE;
        S_DIV:  if (cnt == DIV_LAST) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: if (bus.i_ready) state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl         <= '0;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.o_result <= '0;
      bus.o_mul_s  <= '0;
      bus.o_mul_a  <= '0;
      bus.o_mul_b  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          ctrl        <= bus.i_ctrl;
          bus.o_mul_s <= bus.i_ctrl[1:0];
          bus.o_mul_a <= bus.i_dataa;
          bus.o_mul_b <= bus.i_datab;
          cnt         <= '0;
          rem         <= '0;
          // Signed divides iterate on magnitudes; signs are restored in FIX
          quo         <= (req_signed && bus.i_dataa[31]) ? -bus.i_dataa : bus.i_dataa;
          dvsr        <= (req_signed && bus.i_datab[31]) ? -bus.i_datab : bus.i_datab;
          neg_q       <= req_signed && (bus.i_dataa[31] ^ bus.i_datab[31]);
          neg_r       <= req_signed && bus.i_dataa[31];
          if (!req_mul && !req_slow_div) bus.o_result <= fast_result;
        end
        S_MUL: begin
          cnt <= cnt + 6'd1;
          if (cnt == MUL_LAST)
            bus.o_result <= (ctrl == OP_MUL) ? bus.i_mul_out[31:0] : bus.i_mul_out[63:32];
        end
        S_DIV: begin
          cnt <= cnt + 6'd1;
          if (!rem_diff[32]) begin
            rem <= rem_diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= rem_shift[31:0];
            quo <= {quo[30:0], 1'b0};
          end
        end
        S_FIX:  bus.o_result <= ctrl_rem ? r_fix : q_fix;
        S_DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (state == S_IDLE);
  assign bus.o_valid = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: two instances (MUL_CYCLE=1 and 2) share one stimulus stream and are
// compared every cycle against an arithmetic reference of results and handshake timing.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid, flush, rdy;
  logic [3:0]  ctrl;
  logic [31:0] opa, opb;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Full 64-bit product with RISC-V operand signedness for each multiply sub-op
  function automatic logic [63:0] mul_prod(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (s != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (s[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] model_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0]        p;
    logic               ovf;
    sa  = a;
    sb  = b;
    p   = mul_prod(c[1:0], a, b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (c)
      4'b0000:                   return p[31:0];
      4'b0001, 4'b0010, 4'b0011: return p[63:32];
      4'b0100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      4'b0101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b0110: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      4'b1011: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Cycles from the accept cycle to the first cycle with o_valid
  function automatic int latency(input int mc, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic sg;
    sg = (c == 4'b0100) || (c == 4'b0110);
    if (c[3:2] == 2'b00) return 2 * mc;
    if (!(c inside {4'b0100, 4'b0101, 4'b0110, 4'b1011})) return 1;
    if (b == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  muldiv_seq_if mif0();
  muldiv_seq_if mif1();

  assign mif0.i_valid = valid;  assign mif1.i_valid = valid;
  assign mif0.i_ctrl  = ctrl;   assign mif1.i_ctrl  = ctrl;
  assign mif0.i_dataa = opa;    assign mif1.i_dataa = opa;
  assign mif0.i_datab = opb;    assign mif1.i_datab = opb;
  assign mif0.i_flush = flush;  assign mif1.i_flush = flush;
  assign mif0.i_ready = rdy;    assign mif1.i_ready = rdy;

  // Multiplier models: combinational for instance 0, two register stages for instance 1
  logic [63:0] pipe1, pipe2;
  assign mif0.i_mul_out = mul_prod(mif0.o_mul_s, mif0.o_mul_a, mif0.o_mul_b);
  always @(posedge clk) begin
    pipe1 <= mul_prod(mif1.o_mul_s, mif1.o_mul_a, mif1.o_mul_b);
    pipe2 <= pipe1;
  end
  assign mif1.i_mul_out = pipe2;

  muldiv_seq #(.MUL_CYCLE(1)) u_dut0 (.clk(clk), .rst(rst), .bus(mif0));
  muldiv_seq #(.MUL_CYCLE(2)) u_dut1 (.clk(clk), .rst(rst), .bus(mif1));

  // Reference state per instance
  bit          busy [2];
  int          due  [2];
  logic [31:0] exp_res [2];
  logic [3:0]  exp_c;
  logic [31:0] exp_a, exp_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare outputs of the current cycle, advance the reference over the coming edge,
  // then move to the next falling edge. Inputs set before the call act on that edge.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      logic        ov, ordy;
      logic [31:0] res, ma, mb;
      logic [1:0]  ms;
      ov   = (d == 0) ? mif0.o_valid  : mif1.o_valid;
      ordy = (d == 0) ? mif0.o_ready  : mif1.o_ready;
      res  = (d == 0) ? mif0.o_result : mif1.o_result;
      ma   = (d == 0) ? mif0.o_mul_a  : mif1.o_mul_a;
      mb   = (d == 0) ? mif0.o_mul_b  : mif1.o_mul_b;
      ms   = (d == 0) ? mif0.o_mul_s  : mif1.o_mul_s;
      if (busy[d]) begin
        check($sformatf("dut%0d o_valid", d), ov, cyc >= due[d]);
        check($sformatf("dut%0d o_ready", d), ordy, 1'b0);
        if (cyc >= due[d]) check($sformatf("dut%0d o_result", d), res, exp_res[d]);
        check($sformatf("dut%0d o_mul_a", d), ma, exp_a);
        check($sformatf("dut%0d o_mul_b", d), mb, exp_b);
        check($sformatf("dut%0d o_mul_s", d), ms, exp_c[1:0]);
      end else begin
        check($sformatf("dut%0d idle o_valid", d), ov, 1'b0);
        check($sformatf("dut%0d idle o_ready", d), ordy, 1'b1);
      end
      if (rst || flush) busy[d] = 1'b0;
      else if (busy[d] && cyc >= due[d] && rdy) busy[d] = 1'b0;
      else if (!busy[d] && valid) begin
        busy[d]    = 1'b1;
        due[d]     = cyc + latency(d + 1, ctrl, opa, opb);
        exp_res[d] = model_result(ctrl, opa, opb);
        exp_c      = ctrl;
        exp_a      = opa;
        exp_b      = opb;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    ctrl  = c;
    opa   = a;
    opb   = b;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      step();
      n++;
    end
    check("operation retired within budget", busy[0] || busy[1], 1'b0);
  endtask

  task automatic directed(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
    check($sformatf("model %s", name), model_result(c, a, b), lit);
    issue(c, a, b);
    wait_idle(100);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(1, 16));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] op_pool [11];

  initial begin
    op_pool = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB, 4'h7, 4'h9, 4'hF};
    valid = 1'b0; flush = 1'b0; rdy = 1'b1; ctrl = '0; opa = '0; opb = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset dut0 o_result", mif0.o_result, 32'h0);
    check("reset dut1 o_result", mif1.o_result, 32'h0);
    check("reset dut0 o_mul", {mif0.o_mul_s, mif0.o_mul_a, mif0.o_mul_b}, 66'h0);
    check("reset dut1 o_mul", {mif1.o_mul_s, mif1.o_mul_a, mif1.o_mul_b}, 66'h0);
    step();

    check("latency MUL mc1", latency(1, 4'h1, 32'h5, 32'h3), 2);
    check("latency MUL mc2", latency(2, 4'h3, 32'h5, 32'h3), 4);
    check("latency DIV", latency(1, 4'h4, 32'hFFFF_FFF9, 32'h2), 34);
    check("latency DIVU by zero", latency(1, 4'h5, 32'd100, 32'h0), 1);

    directed("MULH min*min", 4'h1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    directed("MULHU max*max", 4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("MUL max*max", 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    directed("MULHSU -1*2", 4'h2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
    directed("DIV -7/2", 4'h4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    directed("REM -7/2", 4'h6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    directed("DIVU 100/7", 4'h5, 32'd100, 32'd7, 32'd14);
    directed("REMU 100/7", 4'hB, 32'd100, 32'd7, 32'd2);
    directed("DIVU 100/0", 4'h5, 32'd100, 32'd0, 32'hFFFF_FFFF);
    directed("REMU 100/0", 4'hB, 32'd100, 32'd0, 32'd100);
    directed("DIV overflow", 4'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed("REM overflow", 4'h6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    directed("undefined 0111", 4'h7, 32'd9, 32'd3, 32'h0);

    // Flush during a divide: accepted at T, flushed in T+10
    issue(4'h4, 32'd1000, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle(5);
    directed("MUL 6*7", 4'h0, 32'd6, 32'd7, 32'd42);

    // Flush wins over a same-cycle request
    ctrl = 4'h0; opa = 32'd2; opb = 32'd2; valid = 1'b1; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0;
    step();

    // Result held while the consumer stalls
    rdy = 1'b0;
    check("model MUL 3*5", model_result(4'h0, 32'd3, 32'd5), 32'd15);
    issue(4'h0, 32'd3, 32'd5);
    repeat (7) step();
    rdy = 1'b1;
    wait_idle(10);

    // Flush together with i_ready while results are waiting
    rdy = 1'b0;
    issue(4'h1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) step();
    rdy = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle(5);

    // Reset in the middle of a divide
    issue(4'h5, 32'd123456, 32'd7);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-op reset dut0 o_result", mif0.o_result, 32'h0);
    check("mid-op reset dut1 o_mul_a", mif1.o_mul_a, 32'h0);
    step();

    // Randomized operations with consumer stalls and occasional flushes
    for (int i = 0; i < 80; i++) begin
      int n;
      issue(op_pool[$urandom_range(0, 10)], pick_operand(), pick_operand());
      n = 0;
      while ((busy[0] || busy[1]) && n < 300) begin
        rdy   = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 99) == 0);
        step();
        n++;
      end
      flush = 1'b0;
      rdy   = 1'b1;
      wait_idle(100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
